// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back / write-allocate data cache with true-LRU replacement.
// Defining CACHE_STATS_EN adds saturating hit_count, miss_count and writeback_count outputs.
module cache_nway_wb #(
    parameter int RAM_ADDRESS_BITS = 32,
    parameter int INDEX_BITS       = 6,
    parameter int DATA_BITS        = 32,
    parameter int WAYS             = 4,
    parameter int BLOCK_WORDS      = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [RAM_ADDRESS_BITS-1:0]      address,
    input  logic                             read_en,
    input  logic                             write_en,
    input  logic [DATA_BITS-1:0]             write_data,
    output logic [DATA_BITS-1:0]             read_data,
    output logic                             valid,
    output logic                             busy,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [RAM_ADDRESS_BITS-1:0]      mem_address,
    output logic [DATA_BITS*BLOCK_WORDS-1:0] mem_wdata,
    input  logic                             mem_ack,
    input  logic [DATA_BITS*BLOCK_WORDS-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                      hit_count,
    output logic [31:0]                      miss_count,
    output logic [31:0]                      writeback_count
`endif
);
    localparam int OB       = $clog2(BLOCK_WORDS);
    localparam int OW       = (OB > 0) ? OB : 1;
    localparam int LW       = $clog2(WAYS);
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = RAM_ADDRESS_BITS - INDEX_BITS - OB;
    localparam int BLK_BITS = DATA_BITS * BLOCK_WORDS;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2} state_t;
    state_t state_r, state_s;

    logic [TAG_BITS-1:0] tag_r   [WAYS][SETS];
    logic [BLK_BITS-1:0] data_r  [WAYS][SETS];
    logic [WAYS-1:0]     valid_r [SETS];
    logic [WAYS-1:0]     dirty_r [SETS];
    logic [WAYS*LW-1:0]  lru_r   [SETS];

    logic [TAG_BITS-1:0]   req_tag_r;
    logic [INDEX_BITS-1:0] req_idx_r;
    logic [OW-1:0]         req_off_r;
    logic [DATA_BITS-1:0]  req_wdata_r;
    logic                  req_write_r;
    logic [LW-1:0]         vic_r;

    logic [TAG_BITS-1:0]   in_tag_s;
    logic [INDEX_BITS-1:0] in_idx_s;
    logic [OW-1:0]         in_off_s;
    logic                  accept_s, ack_s, hit_s, inv_found_s, vic_dirty_s, hit_wr_s, fill_done_s;
    logic [LW-1:0]         hit_way_s, inv_way_s, old_way_s, vic_way_s;
    logic [BLK_BITS-1:0]   fill_blk_s;

    // Accessed way becomes most recent; ways more recent than it move down by one.
    function automatic logic [WAYS*LW-1:0] lru_touch(input logic [WAYS*LW-1:0] cur, input logic [LW-1:0] way);
        logic [LW-1:0]      old_c;
        logic [WAYS*LW-1:0] nxt;
        old_c = cur[int'(way)*LW +: LW];
        nxt   = cur;
        for (int w = 0; w < WAYS; w++) begin
            nxt[w*LW +: LW] = (cur[w*LW +: LW] > old_c) ? cur[w*LW +: LW] - LW'(1) : cur[w*LW +: LW];
        end
        nxt[int'(way)*LW +: LW] = LW'(WAYS - 1);
        return nxt;
    endfunction

    function automatic logic [RAM_ADDRESS_BITS-1:0] blk_addr(input logic [TAG_BITS-1:0] tag, input logic [INDEX_BITS-1:0] idx);
        return RAM_ADDRESS_BITS'({tag, idx}) << OB;
    endfunction

    assign in_off_s    = OW'(address & RAM_ADDRESS_BITS'(BLOCK_WORDS - 1));
    assign in_idx_s    = INDEX_BITS'(address >> OB);
    assign in_tag_s    = TAG_BITS'(address >> (OB + INDEX_BITS));
    assign accept_s    = (state_r == IDLE) & (read_en | write_en);
    assign ack_s       = mem_req & mem_ack;
    assign hit_wr_s    = accept_s & hit_s & write_en;
    assign fill_done_s = (state_r == FILL) & ack_s;
    assign vic_way_s   = inv_found_s ? inv_way_s : old_way_s;
    assign vic_dirty_s = valid_r[in_idx_s][vic_way_s] & dirty_r[in_idx_s][vic_way_s];

    // Tag compare plus lowest invalid way and LRU-count-zero way of the addressed set.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        old_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s   = (valid_r[in_idx_s][w] && tag_r[w][in_idx_s] == in_tag_s) ? LW'(w) : hit_way_s;
            hit_s       = hit_s | (valid_r[in_idx_s][w] && tag_r[w][in_idx_s] == in_tag_s);
            inv_way_s   = !valid_r[in_idx_s][w] ? LW'(w) : inv_way_s;
            inv_found_s = inv_found_s | !valid_r[in_idx_s][w];
            old_way_s   = (valid_r[in_idx_s][w] && lru_r[in_idx_s][w*LW +: LW] == LW'(0)) ? LW'(w) : old_way_s;
        end
    end

    // Refill block with a pending store merged in at its offset.
    always_comb begin
        fill_blk_s = mem_rdata;
        if (req_write_r) begin
            fill_blk_s[int'(req_off_r)*DATA_BITS +: DATA_BITS] = req_wdata_r;
        end else begin
            fill_blk_s = mem_rdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:      state_s = (accept_s && !hit_s) ? (vic_dirty_s ? WRITEBACK : FILL) : IDLE;
            WRITEBACK: state_s = ack_s ? FILL : WRITEBACK;
            FILL:      state_s = ack_s ? IDLE : FILL;
            default:   state_s = IDLE;
        endcase
    end

    // Data and tag arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (hit_wr_s) begin
            data_r[hit_way_s][in_idx_s][int'(in_off_s)*DATA_BITS +: DATA_BITS] <= write_data;
        end else if (fill_done_s) begin
            data_r[vic_r][req_idx_r] <= fill_blk_s;
            tag_r[vic_r][req_idx_r]  <= req_tag_r;
        end
    end

    // State, per-set status bits, request latch and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                lru_r[s]   <= '0;
            end
            read_data   <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            req_tag_r   <= '0;
            req_idx_r   <= '0;
            req_off_r   <= '0;
            req_wdata_r <= '0;
            req_write_r <= 1'b0;
            vic_r       <= '0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            valid   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && hit_s) begin
                        valid     <= 1'b1;
                        read_data <= write_en ? write_data
                                              : data_r[hit_way_s][in_idx_s][int'(in_off_s)*DATA_BITS +: DATA_BITS];
                        lru_r[in_idx_s] <= lru_touch(lru_r[in_idx_s], hit_way_s);
                        if (write_en) begin
                            dirty_r[in_idx_s][hit_way_s] <= 1'b1;
                        end
                    end else if (accept_s) begin
                        req_tag_r   <= in_tag_s;
                        req_idx_r   <= in_idx_s;
                        req_off_r   <= in_off_s;
                        req_wdata_r <= write_data;
                        req_write_r <= write_en;
                        vic_r       <= vic_way_s;
                        mem_req     <= 1'b1;
                        mem_we      <= vic_dirty_s;
                        mem_address <= vic_dirty_s ? blk_addr(tag_r[vic_way_s][in_idx_s], in_idx_s)
                                                   : blk_addr(in_tag_s, in_idx_s);
                        mem_wdata   <= data_r[vic_way_s][in_idx_s];
                    end
                end
                WRITEBACK: begin
                    if (ack_s) begin
                        dirty_r[req_idx_r][vic_r] <= 1'b0;
                        mem_req                   <= 1'b0;
                        mem_we                    <= 1'b0;
                    end
                end
                FILL: begin
                    // Entered with mem_req low only after a write-back: re-raise after the one-cycle gap.
                    if (!mem_req) begin
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_address <= blk_addr(req_tag_r, req_idx_r);
                    end else if (ack_s) begin
                        mem_req                   <= 1'b0;
                        valid_r[req_idx_r][vic_r] <= 1'b1;
                        dirty_r[req_idx_r][vic_r] <= req_write_r;
                        lru_r[req_idx_r]          <= lru_touch(lru_r[req_idx_r], vic_r);
                        valid                     <= 1'b1;
                        read_data                 <= fill_blk_s[int'(req_off_r)*DATA_BITS +: DATA_BITS];
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count       <= 32'd0;
            miss_count      <= 32'd0;
            writeback_count <= 32'd0;
        end else begin
            if (accept_s && hit_s) begin
                hit_count <= sat_inc(hit_count);
            end
            if (accept_s && !hit_s) begin
                miss_count <= sat_inc(miss_count);
            end
            if ((state_r == WRITEBACK) && ack_s) begin
                writeback_count <= sat_inc(writeback_count);
            end
        end
    end
`endif
endmodule

// File: tb/tb_cache_nway_wb.sv
// Self-checking bench for cache_nway_wb (default parameters): directed scenarios, then random
// accesses checked against a timestamp-LRU cache model backed by an associative memory.
module tb_cache_nway_wb;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  address = 32'd0;
    logic         read_en = 1'b0;
    logic         write_en = 1'b0;
    logic [31:0]  write_data = 32'd0;
    logic [31:0]  read_data;
    logic         valid, busy, mem_req, mem_we;
    logic [31:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = 128'd0;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count, writeback_count;
`endif

    cache_nway_wb dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read_en(read_en), .write_en(write_en),
        .write_data(write_data), .read_data(read_data), .valid(valid), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
    );

    always #5 clk = ~clk;

    int num_tests = 0;
    int num_fails = 0;

    bit          m_valid [64][4];
    bit          m_dirty [64][4];
    logic [31:0] m_tag   [64][4];
    logic [31:0] m_data  [64][4][4];
    int          m_stamp [64][4];
    int          now_t;
    int          hits_m, misses_m, wbs_m;
    logic [31:0] mem_model [logic [31:0]];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        num_tests++;
        if (obs !== exp) begin
            num_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
        hits_m = 0; misses_m = 0; wbs_m = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rst_read_data", read_data, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_address", mem_address, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        model_clear();
    endtask

    // Returns #1 after the edge that samples the acknowledge.
    task automatic ack_mem(input logic [127:0] blk);
        int d;
        d = $urandom_range(0, 3);
        repeat (d) begin
            @(posedge clk); #1;
            check_eq("req_held", mem_req, 1);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = blk;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd);
        int idx, off, way, vic;
        logic [31:0] tg, base, vbase;
        logic [127:0] blk;
        bit hit;
        idx  = int'((a >> 2) & 32'h3F);
        off  = int'(a & 32'h3);
        tg   = a >> 8;
        base = a & ~32'h3;
        hit = 1'b0; way = 0;
        for (int w = 0; w < 4; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) begin hit = 1'b1; way = w; end
        now_t++;
        @(negedge clk);
        address = a; read_en = rd; write_en = wr; write_data = wd;
        @(posedge clk); #1;
        address = $urandom; read_en = 1'b0; write_en = 1'b0; write_data = $urandom;
        if (hit) begin
            hits_m++;
            if (wr) begin
                m_data[idx][way][off] = wd;
                m_dirty[idx][way] = 1'b1;
            end
            m_stamp[idx][way] = now_t;
            check_eq("hit_valid", valid, 1);
            check_eq("hit_busy", busy, 0);
            check_eq("hit_no_req", mem_req, 0);
            check_eq("hit_data", read_data, m_data[idx][way][off]);
        end else begin
            misses_m++;
            vic = -1;
            for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) vic = w;
            if (vic < 0) begin
                vic = 0;
                for (int w = 1; w < 4; w++) if (m_stamp[idx][w] < m_stamp[idx][vic]) vic = w;
            end
            check_eq("miss_busy", busy, 1);
            check_eq("miss_req", mem_req, 1);
            check_eq("miss_valid_low", valid, 0);
            if (m_valid[idx][vic] && m_dirty[idx][vic]) begin
                wbs_m++;
                vbase = (m_tag[idx][vic] << 8) | (32'(idx) << 2);
                for (int k = 0; k < 4; k++) begin
                    blk[k*32 +: 32] = m_data[idx][vic][k];
                    mem_model[vbase + 32'(k)] = m_data[idx][vic][k];
                end
                check_eq("wb_we", mem_we, 1);
                check_eq("wb_address", mem_address, vbase);
                check_eq("wb_wdata", mem_wdata, blk);
                ack_mem({$urandom, $urandom, $urandom, $urandom});
                check_eq("wb_gap_req", mem_req, 0);
                check_eq("wb_gap_busy", busy, 1);
                @(posedge clk); #1;
                check_eq("fill_req_after_gap", mem_req, 1);
            end
            check_eq("fill_we", mem_we, 0);
            check_eq("fill_address", mem_address, base);
            for (int k = 0; k < 4; k++) blk[k*32 +: 32] = mem_rd(base + 32'(k));
            ack_mem(blk);
            m_valid[idx][vic] = 1'b1;
            m_tag[idx][vic]   = tg;
            m_dirty[idx][vic] = wr;
            m_stamp[idx][vic] = now_t;
            for (int k = 0; k < 4; k++) m_data[idx][vic][k] = blk[k*32 +: 32];
            if (wr) m_data[idx][vic][off] = wd;
            check_eq("fill_valid", valid, 1);
            check_eq("fill_busy", busy, 0);
            check_eq("fill_req_drop", mem_req, 0);
            check_eq("fill_data", read_data, m_data[idx][vic][off]);
        end
    endtask

    initial begin
        now_t = 0;
        model_clear();
        do_reset();

        // Cold miss with a known block, then a hit in the same block.
        mem_model[32'h10000] = 32'd1;
        mem_model[32'h10001] = 32'd2;
        mem_model[32'h10002] = 32'd3;
        mem_model[32'h10003] = 32'd4;
        do_access(32'h10000, 1'b1, 1'b0, 32'd0);
        check_eq("cold_word0", read_data, 32'h1);
        do_access(32'h10002, 1'b1, 1'b0, 32'd0);
        check_eq("hit_word2", read_data, 32'h3);

        // Write hit then read back.
        do_access(32'h10001, 1'b0, 1'b1, 32'hAA);
        do_access(32'h10001, 1'b1, 1'b0, 32'd0);
        check_eq("readback_aa", read_data, 32'hAA);

        // LRU dirty eviction from a clean start.
        do_reset();
        do_access(32'h10000, 1'b0, 1'b1, 32'h1111);
        do_access(32'h20000, 1'b0, 1'b1, 32'h2222);
        do_access(32'h30000, 1'b0, 1'b1, 32'h3333);
        do_access(32'h40000, 1'b0, 1'b1, 32'h4444);
        do_access(32'h10000, 1'b1, 1'b0, 32'd0);
        do_access(32'h50000, 1'b1, 1'b0, 32'd0);
        check_eq("evicted_to_mem", mem_model[32'h20000], 32'h2222);
`ifdef CACHE_STATS_EN
        check_eq("stats_hits", hit_count, 32'd1);
        check_eq("stats_misses", miss_count, 32'd5);
        check_eq("stats_writebacks", writeback_count, 32'd1);
`endif

        // Simultaneous read and write is a write.
        do_access(32'h10003, 1'b1, 1'b1, 32'h55);
        check_eq("rw_as_write", read_data, 32'h55);

        // Asynchronous reset in the middle of a fill.
        @(negedge clk);
        address = 32'h70000; read_en = 1'b1;
        @(posedge clk); #1;
        read_en = 1'b0;
        check_eq("midfill_req", mem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_req", mem_req, 0);
        check_eq("async_rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        do_access(32'h10000, 1'b1, 1'b0, 32'd0);

        // Randomised traffic over a few sets with more tags than ways.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int sel;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                mem_ack = 1'b1;
                @(posedge clk); #1;
                mem_ack = 1'b0;
                check_eq("stray_ack_req", mem_req, 0);
                check_eq("stray_ack_valid", valid, 0);
            end
            a = (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            sel = $urandom_range(0, 2);
            do_access(a, sel != 1, sel != 0, $urandom);
        end
`ifdef CACHE_STATS_EN
        check_eq("stats_hits_final", hit_count, 32'(hits_m));
        check_eq("stats_misses_final", miss_count, 32'(misses_m));
        check_eq("stats_wbs_final", writeback_count, 32'(wbs_m));
`endif

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fails);
        $finish;
    end
endmodule
